// File: rtl/ins_cache_pkg.sv
// Shared geometry and FSM encodings for the direct-mapped instruction cache.
package ins_cache_pkg;

   localparam int unsigned LineCount  = 8;
   localparam int unsigned IdxW       = 3;
   localparam int unsigned TagW       = 25;
   localparam int unsigned OffW       = 2;
   localparam int unsigned BlockW     = 128;
   localparam int unsigned WordW      = 32;
   localparam int unsigned BlockAddrW = 28;

   // Codes 2'b10 and 2'b11 are unused and recover to StIdle.
   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StFetch = 2'b01
   } state_e;

endpackage

// File: rtl/ins_cache_if.sv
// CPU fetch port and instruction-memory block port of the cache.
interface ins_cache_if;
   import ins_cache_pkg::*;

   logic                  read;
   logic [31:0]           address;
   logic [WordW-1:0]      instruction;
   logic                  busywait;
   logic                  mem_read;
   logic [BlockAddrW-1:0] mem_address;
   logic [BlockW-1:0]     mem_readdata;
   logic                  mem_busywait;

   modport master (
      output read, address, mem_readdata, mem_busywait,
      input  instruction, busywait, mem_read, mem_address
   );

   modport slave (
      input  read, address, mem_readdata, mem_busywait,
      output instruction, busywait, mem_read, mem_address
   );

endinterface

// File: rtl/icache_line_store.sv
// Data array: 8 lines of 128 bits, one write port, combinational word read.
module icache_line_store
   import ins_cache_pkg::*;
(
   input  logic              clk,
   input  logic              we_i,
   input  logic [IdxW-1:0]   widx_i,
   input  logic [BlockW-1:0] wdata_i,
   input  logic [IdxW-1:0]   ridx_i,
   input  logic [OffW-1:0]   roff_i,
   output logic [WordW-1:0]  rword_o
);

   logic [BlockW-1:0] mem_q [LineCount];
   logic [3:0][WordW-1:0] line;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[widx_i] <= wdata_i;
   end

   // Word k occupies bits [32k+31:32k].
   assign line    = mem_q[ridx_i];
   assign rword_o = line[roff_i];

endmodule

// File: rtl/ins_cache.sv
// Direct-mapped instruction cache: tag/valid storage and the refill FSM.
module ins_cache
   import ins_cache_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   ins_cache_if.slave   bus
);

   state_e                state_q, state_d;
   logic [TagW-1:0]       tag_q [LineCount];
   logic [LineCount-1:0]  valid_q;
   logic [BlockAddrW-1:0] miss_q;

   logic [TagW-1:0]  req_tag;
   logic [IdxW-1:0]  req_idx;
   logic [OffW-1:0]  req_off;
   logic [IdxW-1:0]  miss_idx;
   logic [TagW-1:0]  miss_tag;
   logic             hit;
   logic             refill;
   logic             busy;
   logic             fetch;
   logic [WordW-1:0] rword;
   logic             unused_addr;

   assign req_tag     = bus.address[31:7];
   assign req_idx     = bus.address[6:4];
   assign req_off     = bus.address[3:2];
   assign unused_addr = ^bus.address[1:0];
   assign miss_idx    = miss_q[IdxW-1:0];
   assign miss_tag    = miss_q[BlockAddrW-1:IdxW];

   assign hit    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign refill = (state_q == StFetch) && !bus.mem_busywait;

   icache_line_store u_line_store (
      .clk     (clk),
      .we_i    (refill),
      .widx_i  (miss_idx),
      .wdata_i (bus.mem_readdata),
      .ridx_i  (req_idx),
      .roff_i  (req_off),
      .rword_o (rword)
   );

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      fetch   = 1'b0;
      case (state_q)
         StIdle: begin
            if (bus.read && !hit) begin
               busy    = 1'b1;
               state_d = StFetch;
            end
         end
         StFetch: begin
            busy  = 1'b1;
            fetch = 1'b1;
            if (!bus.mem_busywait) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are forced quiet while reset is held, independent of the hit path.
   assign bus.busywait    = busy & ~rst;
   assign bus.mem_read    = fetch & ~rst;
   assign bus.mem_address = miss_q;
   assign bus.instruction = rst ? '0 : rword;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         valid_q <= '0;
         miss_q  <= '0;
         for (int i = 0; i < LineCount; i++) tag_q[i] <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && state_d == StFetch) miss_q <= bus.address[31:4];
         if (refill) begin
            tag_q[miss_idx]   <= miss_tag;
            valid_q[miss_idx] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ins_cache.sv
// Directed bench for ins_cache with a behavioural block memory responder.
module tb_ins_cache;
   import ins_cache_pkg::*;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   busy_cycles = 4;
   int   mcnt = 0;
   int   txn = 0;
   logic mr_prev = 1'b0;

   ins_cache_if bus ();

   ins_cache u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory word at byte address a is the word-aligned address xor a marker.
   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [127:0] block_of(input logic [27:0] b);
      logic [127:0] d;
      for (int k = 0; k < 4; k++) d[32*k +: 32] = word_of({b, 4'(k * 4)});
      return d;
   endfunction

   always @(posedge clk) begin
      if (bus.mem_read) mcnt <= mcnt + 1;
      else              mcnt <= 0;
      mr_prev <= bus.mem_read;
      if (bus.mem_read && !mr_prev) txn <= txn + 1;
   end

   assign bus.mem_busywait = bus.mem_read && (mcnt < busy_cycles);
   assign bus.mem_readdata = block_of(bus.mem_address);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Counts busy cycles until the current request is served; notes the first fetch address.
   task automatic wait_hit(output int n, output logic [31:0] seen);
      n    = 0;
      seen = 32'hFFFF_FFFF;
      while (bus.busywait === 1'b1 && n < 400) begin
         if (bus.mem_read === 1'b1 && seen == 32'hFFFF_FFFF) seen = 32'(bus.mem_address);
         @(posedge clk);
         #2;
         n++;
      end
   endtask

   initial begin
      int          n;
      int          t0;
      logic [31:0] seen;

      rst         = 1'b1;
      bus.read    = 1'b1;
      bus.address = 32'h0;
      #12;
      check("rst_mem_read", 32'(bus.mem_read), 32'h0);
      check("rst_mem_addr", 32'(bus.mem_address), 32'h0);
      check("rst_busywait", 32'(bus.busywait), 32'h0);
      check("rst_instr", bus.instruction, 32'h0);

      // Cold miss on 0x0 with a 4-cycle memory.
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("cold_busy", 32'(bus.busywait), 32'h1);
      check("cold_no_memread_idle", 32'(bus.mem_read), 32'h0);
      wait_hit(n, seen);
      check("cold_penalty", n, 6);
      check("cold_mem_addr", seen, 32'h0);
      check("cold_instr", bus.instruction, 32'h5A5A_0000);

      // Same-line hits.
      bus.address = 32'h4; #1;
      check("hit4_busy", 32'(bus.busywait), 32'h0);
      check("hit4_instr", bus.instruction, 32'h5A5A_0004);
      bus.address = 32'h8; #1;
      check("hit8_instr", bus.instruction, 32'h5A5A_0008);
      bus.address = 32'hC; #1;
      check("hitC_busy", 32'(bus.busywait), 32'h0);
      check("hitC_instr", bus.instruction, 32'h5A5A_000C);
      @(posedge clk); #2;
      check("hits_no_txn", txn, 1);

      // Conflict eviction in index 0.
      bus.address = 32'h80; #1;
      check("conf_busy", 32'(bus.busywait), 32'h1);
      wait_hit(n, seen);
      check("conf_penalty", n, 6);
      check("conf_mem_addr", seen, 32'h8);
      check("conf_instr", bus.instruction, 32'h5A5A_0080);
      bus.address = 32'h0; #1;
      check("evict_busy", 32'(bus.busywait), 32'h1);
      wait_hit(n, seen);
      check("evict_mem_addr", seen, 32'h0);
      check("evict_instr", bus.instruction, 32'h5A5A_0000);

      // Address changes one cycle into FETCH; refill keeps the latched address.
      bus.address = 32'h10; #1;
      @(posedge clk); #2;
      check("sw_mem_addr", 32'(bus.mem_address), 32'h1);
      bus.address = 32'h20; #1;
      n = 0;
      while (bus.mem_read === 1'b1 && n < 400) begin
         @(posedge clk); #2; n++;
      end
      check("sw_fetch_len", n, 5);
      check("sw_20_misses", 32'(bus.busywait), 32'h1);
      bus.address = 32'h10; #1;
      check("sw_10_hits", 32'(bus.busywait), 32'h0);
      check("sw_10_instr", bus.instruction, 32'h5A5A_0010);
      bus.address = 32'h20; #1;
      wait_hit(n, seen);
      check("sw_20_penalty", n, 6);
      check("sw_20_mem_addr", seen, 32'h2);
      check("sw_20_instr", bus.instruction, 32'h5A5A_0020);

      // Reset on the second FETCH cycle abandons the refill.
      bus.address = 32'h40; #1;
      @(posedge clk); #2;
      @(posedge clk); #2;
      check("rf_mem_read", 32'(bus.mem_read), 32'h1);
      rst = 1'b1; #1;
      check("rf_drop_mem_read", 32'(bus.mem_read), 32'h0);
      check("rf_mem_addr_clr", 32'(bus.mem_address), 32'h0);
      check("rf_instr_zero", bus.instruction, 32'h0);
      rst = 1'b0;
      bus.address = 32'h10; #1;
      check("rf_10_misses", 32'(bus.busywait), 32'h1);
      wait_hit(n, seen);
      check("rf_10_penalty", n, 6);
      check("rf_10_mem_addr", seen, 32'h1);
      check("rf_10_instr", bus.instruction, 32'h5A5A_0010);
      bus.address = 32'h40; #1;
      check("rf_40_not_written", 32'(bus.busywait), 32'h1);
      wait_hit(n, seen);
      check("rf_40_instr", bus.instruction, 32'h5A5A_0040);

      // Sequential fetch through 8 fresh lines with a slow memory.
      rst = 1'b1; #1;
      rst = 1'b0; #1;
      busy_cycles = 40;
      t0 = txn;
      for (int a = 0; a < 32'h80; a += 4) begin
         bus.address = 32'(a); #1;
         wait_hit(n, seen);
         check("seq_penalty", n, (a % 16 == 0) ? 42 : 0);
         check("seq_instr", bus.instruction, word_of(32'(a)));
      end
      @(posedge clk); #2;
      check("seq_txn_count", txn - t0, 8);

      // READ low never starts a fetch.
      bus.read    = 1'b0;
      bus.address = 32'h200; #1;
      check("idle_busy", 32'(bus.busywait), 32'h0);
      @(posedge clk); #2;
      check("idle_no_mem_read", 32'(bus.mem_read), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
